// File: rtl/riego_zone_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : riego_zone_scheduler
// Description : Shares one irrigation pump between N_ZONES watering zones.
//               Each check period the zone requests are snapshotted and every
//               requesting zone gets one open-valve / pump-on / drain service,
//               in round-robin order. Pump drive is active-low.
//               Optional macro RIEGO_RUN_COUNT_EN adds per-zone 8-bit
//               saturating counters of completed pump runs (run_count port).
// Revision    : 1.0 - initial release
// ============================================================================
module riego_zone_scheduler #(
    parameter int N_ZONES     = 4,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int CHECK_TICKS = 10,
    parameter int LEAD_TICKS  = 1,
    parameter int ON_TICKS    = 3,
    parameter int LAG_TICKS   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [N_ZONES-1:0] req,
    output logic [N_ZONES-1:0] valve,
    output logic               pump_n,
    output logic               busy,
    output logic [2:0]         cur_zone,
`ifdef RIEGO_RUN_COUNT_EN
    output logic                 done,
    output logic [N_ZONES*8-1:0] run_count
`else
    output logic               done
`endif
);

    // Phase lengths in cycles; a zero-length lead or lag still lasts one cycle.
    localparam longint c_CHECK_CYC = longint'(CHECK_TICKS) * longint'(TICK_CYCLES);
    localparam longint c_LEAD_CYC  = longint'(LEAD_TICKS) * longint'(TICK_CYCLES);
    localparam longint c_ON_CYC    = longint'(ON_TICKS) * longint'(TICK_CYCLES);
    localparam longint c_LAG_CYC   = longint'(LAG_TICKS) * longint'(TICK_CYCLES);

    localparam logic [31:0] c_CHECK_LAST = 32'(c_CHECK_CYC - 1);
    localparam logic [31:0] c_LEAD_LAST  = (c_LEAD_CYC == 0) ? 32'd0 : 32'(c_LEAD_CYC - 1);
    localparam logic [31:0] c_ON_LAST    = 32'(c_ON_CYC - 1);
    localparam logic [31:0] c_LAG_LAST   = (c_LAG_CYC == 0) ? 32'd0 : 32'(c_LAG_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_OPEN  = 3'd2,
        ST_PUMP  = 3'd3,
        ST_CLOSE = 3'd4,
        ST_ABORT = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [N_ZONES-1:0]  snap_q, snap_d;
    logic                pend_q, pend_d;
    logic [31:0]         period_q, period_d;
    logic [31:0]         phase_q, phase_d;
    logic [N_ZONES-1:0]  valve_q, valve_d;
    logic                pump_n_q, pump_n_d;
    logic                busy_q, busy_d;
    logic [2:0]          cur_zone_q, cur_zone_d;
    logic                done_q, done_d;

    logic                w_check_due;
    logic [3:0]          w_pick_scan;   // {found, zone}
    logic [3:0]          w_pick_next;   // {found, zone}
    logic [N_ZONES-1:0]  w_snap_rem;
    logic [2:0]          w_ptr_next;

    // First set bit at or after 'start', wrapping; returns {found, zone}.
    function automatic logic [3:0] pick_zone(input logic [N_ZONES-1:0] bits,
                                             input logic [2:0]         start);
        logic [N_ZONES-1:0] rot;
        logic [3:0]         res;
        rot = N_ZONES'({bits, bits} >> start);
        res = 4'd0;
        for (int j = N_ZONES - 1; j >= 0; j--) begin
            if (rot[j]) res = {1'b1, 3'((int'(start) + j) % N_ZONES)};
        end
        return res;
    endfunction

    function automatic logic [N_ZONES-1:0] onehot(input logic [2:0] z);
        return {{(N_ZONES-1){1'b0}}, 1'b1} << z;
    endfunction

    function automatic logic [2:0] next_ptr(input logic [2:0] z);
        if (z >= 3'(N_ZONES - 1)) return 3'd0;
        return z + 3'd1;
    endfunction

    assign w_check_due = enable && (period_q == c_CHECK_LAST);
    assign w_pick_scan = pick_zone(req, ptr_q);
    assign w_snap_rem  = snap_q & ~onehot(cur_zone_q);
    assign w_ptr_next  = next_ptr(cur_zone_q);
    assign w_pick_next = pick_zone(w_snap_rem, w_ptr_next);

    // Next-state: period timer, pending flag, and the service sequencer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        snap_d     = snap_q;
        pend_d     = pend_q;
        phase_d    = phase_q;
        valve_d    = valve_q;
        pump_n_d   = pump_n_q;
        cur_zone_d = cur_zone_q;
        done_d     = 1'b0;

        if (!enable)                    period_d = 32'd0;
        else if (w_check_due)           period_d = 32'd0;
        else                            period_d = period_q + 32'd1;

        // Checks that expire while busy collapse into a single pending flag.
        if (w_check_due && state_q != ST_IDLE) pend_d = 1'b1;

        if (!enable && state_q != ST_IDLE && state_q != ST_ABORT) begin
            // Pump goes off first; valves close one cycle later in ABORT.
            pump_n_d = 1'b1;
            phase_d  = 32'd0;
            state_d  = ST_ABORT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable && (w_check_due || pend_q)) begin
                        pend_d  = 1'b0;
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    snap_d = req;
                    if (!w_pick_scan[3]) begin
                        state_d = ST_IDLE;
                    end else begin
                        cur_zone_d = w_pick_scan[2:0];
                        valve_d    = onehot(w_pick_scan[2:0]);
                        phase_d    = 32'd0;
                        state_d    = ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (phase_q == c_LEAD_LAST) begin
                        phase_d  = 32'd0;
                        pump_n_d = 1'b0;
                        state_d  = ST_PUMP;
                    end else begin
                        phase_d = phase_q + 32'd1;
                    end
                end
                ST_PUMP: begin
                    if (phase_q == c_ON_LAST) begin
                        phase_d  = 32'd0;
                        pump_n_d = 1'b1;
                        state_d  = ST_CLOSE;
                    end else begin
                        phase_d = phase_q + 32'd1;
                    end
                end
                ST_CLOSE: begin
                    if (phase_q == c_LAG_LAST) begin
                        phase_d = 32'd0;
                        snap_d  = w_snap_rem;
                        ptr_d   = w_ptr_next;
                        if (w_pick_next[3]) begin
                            // Hand the pump straight to the next zone, no idle gap.
                            cur_zone_d = w_pick_next[2:0];
                            valve_d    = onehot(w_pick_next[2:0]);
                            state_d    = ST_OPEN;
                        end else begin
                            valve_d    = '0;
                            cur_zone_d = 3'd0;
                            done_d     = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        phase_d = phase_q + 32'd1;
                    end
                end
                ST_ABORT: begin
                    valve_d    = '0;
                    snap_d     = '0;
                    pend_d     = 1'b0;
                    cur_zone_d = 3'd0;
                    state_d    = ST_IDLE;
                end
                default: begin
                    valve_d    = '0;
                    pump_n_d   = 1'b1;
                    cur_zone_d = 3'd0;
                    state_d    = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'd0;
            snap_q     <= '0;
            pend_q     <= 1'b0;
            period_q   <= 32'd0;
            phase_q    <= 32'd0;
            valve_q    <= '0;
            pump_n_q   <= 1'b1;
            busy_q     <= 1'b0;
            cur_zone_q <= 3'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            snap_q     <= snap_d;
            pend_q     <= pend_d;
            period_q   <= period_d;
            phase_q    <= phase_d;
            valve_q    <= valve_d;
            pump_n_q   <= pump_n_d;
            busy_q     <= busy_d;
            cur_zone_q <= cur_zone_d;
            done_q     <= done_d;
        end
    end

    assign valve    = valve_q;
    assign pump_n   = pump_n_q;
    assign busy     = busy_q;
    assign cur_zone = cur_zone_q;
    assign done     = done_q;

`ifdef RIEGO_RUN_COUNT_EN
    logic [N_ZONES*8-1:0] run_count_q, run_count_d;

    // Count a zone only when its pump run reaches the full ON length uninterrupted.
    always_comb begin
        run_count_d = run_count_q;
        if (state_q == ST_PUMP && enable && phase_q == c_ON_LAST) begin
            for (int k = 0; k < N_ZONES; k++) begin
                if (cur_zone_q == 3'(k) && run_count_q[8*k +: 8] != 8'hFF)
                    run_count_d[8*k +: 8] = run_count_q[8*k +: 8] + 8'd1;
            end
        end
    end

    // Run counters clear only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_count_q <= '0;
        else        run_count_q <= run_count_d;
    end

    assign run_count = run_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riego_zone_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_riego_zone_scheduler
// Description : Self-checking bench for riego_zone_scheduler. DUT A uses the
//               nominal scaled timing, DUT B the short-check / long-pump set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riego_zone_scheduler;

    typedef struct {
        int zone;
        int open_c;
        int vlen;
        int pstart;
        int plen;
    } svc_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [3:0] req_a, req_b;
    logic [3:0] valve_a, valve_b;
    logic       pump_n_a, pump_n_b, busy_a, busy_b, done_a, done_b;
    logic [2:0] cur_a, cur_b;
`ifdef RIEGO_RUN_COUNT_EN
    logic [31:0] rc_a, rc_b;
`endif

    int n_checks;
    int n_fail;
    int cyc;

    svc_t obs_q[$];
    svc_t exp_q[$];
    int   scan_q[$];
    int   done_q[$];
    int   scan_b_q[$];
    int   done_b_q[$];
    int   inv_viol;

    always #5 clk = ~clk;

    riego_zone_scheduler #(
        .N_ZONES(4), .TICK_CYCLES(10), .CHECK_TICKS(20),
        .LEAD_TICKS(1), .ON_TICKS(3), .LAG_TICKS(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .req(req_a),
        .valve(valve_a), .pump_n(pump_n_a), .busy(busy_a),
        .cur_zone(cur_a), .done(done_a)
`ifdef RIEGO_RUN_COUNT_EN
        , .run_count(rc_a)
`endif
    );

    riego_zone_scheduler #(
        .N_ZONES(4), .TICK_CYCLES(10), .CHECK_TICKS(2),
        .LEAD_TICKS(1), .ON_TICKS(5), .LAG_TICKS(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .req(req_b),
        .valve(valve_b), .pump_n(pump_n_b), .busy(busy_b),
        .cur_zone(cur_b), .done(done_b)
`ifdef RIEGO_RUN_COUNT_EN
        , .run_count(rc_b)
`endif
    );

    // Cycle index since reset release; cycle 0 is the one before the first edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int zone_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Monitor: records services, scans, done pulses and safety violations.
    logic [3:0] pv_a;
    logic       pp_a, pb_a, pb_b;
    int         open_c, pst, pln;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv_a = 4'd0; pp_a = 1'b1; pb_a = 1'b0; pb_b = 1'b0;
        end else begin
            if (busy_a && !pb_a) scan_q.push_back(cyc);
            if (done_a) done_q.push_back(cyc);
            if (!pump_n_a && pp_a) pst = cyc;
            if (pump_n_a && !pp_a) pln = cyc - pst;
            if (!pump_n_a && !$onehot(valve_a)) inv_viol++;
            if (valve_a != pv_a) begin
                svc_t s;
                if (!pp_a || !pump_n_a) inv_viol++;
                if (pv_a != 4'd0) begin
                    s.zone = zone_of(pv_a); s.open_c = open_c; s.vlen = cyc - open_c;
                    s.pstart = pst; s.plen = pln;
                    obs_q.push_back(s);
                end
                if (valve_a != 4'd0) begin
                    open_c = cyc; pst = -1; pln = 0;
                end
            end
            pv_a = valve_a; pp_a = pump_n_a; pb_a = busy_a;
            if (busy_b && !pb_b) scan_b_q.push_back(cyc);
            if (done_b) done_b_q.push_back(cyc);
            pb_b = busy_b;
        end
    end

    task automatic do_reset(input logic [3:0] ra, input logic [3:0] rb);
        rst_n = 1'b0;
        en_a = 1'b1; en_b = 1'b1; req_a = ra; req_b = rb;
        repeat (2) @(negedge clk);
        obs_q.delete(); exp_q.delete(); scan_q.delete(); done_q.delete();
        scan_b_q.delete(); done_b_q.delete();
        inv_viol = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    function automatic svc_t mk(input int z, input int open);
        svc_t s;
        s.zone = z; s.open_c = open; s.vlen = 50; s.pstart = open + 10; s.plen = 30;
        return s;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1; req_a = 4'hF; req_b = 4'hF;
        repeat (3) @(negedge clk);
        n_checks++; if (valve_a !== 4'd0) begin n_fail++; $display("FAIL reset_valve got %b exp 0000", valve_a); end
        n_checks++; if (pump_n_a !== 1'b1) begin n_fail++; $display("FAIL reset_pump_n got %b exp 1", pump_n_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_a); end
        n_checks++; if (cur_a !== 3'd0) begin n_fail++; $display("FAIL reset_cur_zone got %0d exp 0", cur_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done_a); end
        n_checks++; if (valve_b !== 4'd0 || pump_n_b !== 1'b1) begin
            n_fail++; $display("FAIL reset_b got valve %b pump_n %b exp 0000 1", valve_b, pump_n_b); end
    endtask

    task automatic test_single_zone;
        int exp_scan[2] = '{200, 400};
        svc_t e, o;
        do_reset(4'b0010, 4'b0000);
        exp_q.push_back(mk(1, 201));
        wait_cyc(230);
        n_checks++; if (cur_a !== 3'd1 || busy_a !== 1'b1 || pump_n_a !== 1'b0) begin
            n_fail++; $display("FAIL single_mid got cur %0d busy %b pump_n %b exp 1 1 0", cur_a, busy_a, pump_n_a); end
        wait_cyc(252);
        n_checks++; if (cur_a !== 3'd0 || busy_a !== 1'b0 || valve_a !== 4'd0) begin
            n_fail++; $display("FAIL single_after got cur %0d busy %b valve %b exp 0 0 0000", cur_a, busy_a, valve_a); end
        wait_cyc(402);
        n_checks++; if (scan_q.size() != 2) begin n_fail++; $display("FAIL single_scan_count got %0d exp 2", scan_q.size()); end
        for (int i = 0; i < 2 && i < scan_q.size(); i++) begin
            n_checks++; if (scan_q[i] != exp_scan[i]) begin n_fail++; $display("FAIL single_scan[%0d] got %0d exp %0d", i, scan_q[i], exp_scan[i]); end
        end
        n_checks++; if (done_q.size() != 1 || done_q[0] != 251) begin
            n_fail++; $display("FAIL single_done got count %0d first %0d exp 1 at 251", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL single_svc got none exp zone %0d open %0d", e.zone, e.open_c); end
            else begin
                o = obs_q.pop_front();
                if (o.zone != e.zone || o.open_c != e.open_c || o.vlen != e.vlen || o.pstart != e.pstart || o.plen != e.plen) begin
                    n_fail++;
                    $display("FAIL single_svc got z%0d open %0d vlen %0d pstart %0d plen %0d exp z%0d open %0d vlen %0d pstart %0d plen %0d",
                             o.zone, o.open_c, o.vlen, o.pstart, o.plen, e.zone, e.open_c, e.vlen, e.pstart, e.plen);
                end
            end
        end
        n_checks++; if (inv_viol != 0) begin n_fail++; $display("FAIL single_invariant got %0d exp 0", inv_viol); end
`ifdef RIEGO_RUN_COUNT_EN
        n_checks++; if (rc_a !== 32'h0000_0100) begin n_fail++; $display("FAIL single_run_count got %h exp 00000100", rc_a); end
`endif
    endtask

    task automatic test_round_robin;
        int exp_done[3] = '{351, 501, 751};
        svc_t e, o;
        do_reset(4'b1011, 4'b0000);
        exp_q.push_back(mk(0, 201)); exp_q.push_back(mk(1, 251)); exp_q.push_back(mk(3, 301));
        wait_cyc(205);
        req_a = 4'b0110;   // zone 3 request drops mid-snapshot; still served
        exp_q.push_back(mk(1, 401)); exp_q.push_back(mk(2, 451));
        wait_cyc(260);
        n_checks++; if (cur_a !== 3'd1) begin n_fail++; $display("FAIL rr_cur_zone got %0d exp 1", cur_a); end
        wait_cyc(505);
        req_a = 4'b1011;
        exp_q.push_back(mk(3, 601)); exp_q.push_back(mk(0, 651)); exp_q.push_back(mk(1, 701));
        wait_cyc(605);
        req_a = 4'b0000;
        wait_cyc(760);
        n_checks++; if (done_q.size() != 3) begin n_fail++; $display("FAIL rr_done_count got %0d exp 3", done_q.size()); end
        for (int i = 0; i < 3 && i < done_q.size(); i++) begin
            n_checks++; if (done_q[i] != exp_done[i]) begin n_fail++; $display("FAIL rr_done[%0d] got %0d exp %0d", i, done_q[i], exp_done[i]); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL rr_svc got none exp zone %0d open %0d", e.zone, e.open_c); end
            else begin
                o = obs_q.pop_front();
                if (o.zone != e.zone || o.open_c != e.open_c || o.vlen != e.vlen || o.pstart != e.pstart || o.plen != e.plen) begin
                    n_fail++;
                    $display("FAIL rr_svc got z%0d open %0d vlen %0d pstart %0d plen %0d exp z%0d open %0d vlen %0d pstart %0d plen %0d",
                             o.zone, o.open_c, o.vlen, o.pstart, o.plen, e.zone, e.open_c, e.vlen, e.pstart, e.plen);
                end
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rr_extra_svc got %0d exp 0", obs_q.size()); end
        n_checks++; if (inv_viol != 0) begin n_fail++; $display("FAIL rr_invariant got %0d exp 0", inv_viol); end
`ifdef RIEGO_RUN_COUNT_EN
        n_checks++; if (rc_a !== 32'h0201_0302) begin n_fail++; $display("FAIL rr_run_count got %h exp 02010302", rc_a); end
`endif
    endtask

    task automatic test_snapshot;
        int exp_done[2] = '{251, 451};
        svc_t e, o;
        do_reset(4'b0001, 4'b0000);
        exp_q.push_back(mk(0, 201));
        wait_cyc(210);
        req_a = 4'b0100;
        exp_q.push_back(mk(2, 401));
        wait_cyc(405);
        req_a = 4'b0000;
        wait_cyc(460);
        n_checks++; if (scan_q.size() != 2) begin n_fail++; $display("FAIL snap_scan_count got %0d exp 2", scan_q.size()); end
        n_checks++; if (done_q.size() != 2) begin n_fail++; $display("FAIL snap_done_count got %0d exp 2", done_q.size()); end
        for (int i = 0; i < 2 && i < done_q.size(); i++) begin
            n_checks++; if (done_q[i] != exp_done[i]) begin n_fail++; $display("FAIL snap_done[%0d] got %0d exp %0d", i, done_q[i], exp_done[i]); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL snap_svc got none exp zone %0d open %0d", e.zone, e.open_c); end
            else begin
                o = obs_q.pop_front();
                if (o.zone != e.zone || o.open_c != e.open_c || o.vlen != e.vlen || o.pstart != e.pstart || o.plen != e.plen) begin
                    n_fail++;
                    $display("FAIL snap_svc got z%0d open %0d vlen %0d pstart %0d plen %0d exp z%0d open %0d vlen %0d pstart %0d plen %0d",
                             o.zone, o.open_c, o.vlen, o.pstart, o.plen, e.zone, e.open_c, e.vlen, e.pstart, e.plen);
                end
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL snap_extra_svc got %0d exp 0", obs_q.size()); end
    endtask

    task automatic test_abort;
        svc_t e, o, ab;
        do_reset(4'b0100, 4'b0000);
        ab.zone = 2; ab.open_c = 201; ab.vlen = 21; ab.pstart = 211; ab.plen = 10;
        exp_q.push_back(ab);
        wait_cyc(220);
        n_checks++; if (pump_n_a !== 1'b0 || cur_a !== 3'd2) begin
            n_fail++; $display("FAIL abort_pre got pump_n %b cur %0d exp 0 2", pump_n_a, cur_a); end
        en_a = 1'b0;
        wait_cyc(221);
        n_checks++; if (pump_n_a !== 1'b1 || valve_a !== 4'b0100) begin
            n_fail++; $display("FAIL abort_pump_off got pump_n %b valve %b exp 1 0100", pump_n_a, valve_a); end
        en_a = 1'b1;
        wait_cyc(222);
        n_checks++; if (valve_a !== 4'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL abort_close got valve %b busy %b done %b exp 0000 0 0", valve_a, busy_a, done_a); end
        exp_q.push_back(mk(2, 422));
        wait_cyc(475);
        n_checks++; if (done_q.size() != 1 || done_q[0] != 472) begin
            n_fail++; $display("FAIL abort_done got count %0d first %0d exp 1 at 472", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1); end
        n_checks++; if (scan_q.size() != 2 || scan_q[1] != 421) begin
            n_fail++; $display("FAIL abort_rescan got count %0d second %0d exp 2 at 421", scan_q.size(), (scan_q.size() > 1) ? scan_q[1] : -1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL abort_svc got none exp zone %0d open %0d", e.zone, e.open_c); end
            else begin
                o = obs_q.pop_front();
                if (o.zone != e.zone || o.open_c != e.open_c || o.vlen != e.vlen || o.pstart != e.pstart || o.plen != e.plen) begin
                    n_fail++;
                    $display("FAIL abort_svc got z%0d open %0d vlen %0d pstart %0d plen %0d exp z%0d open %0d vlen %0d pstart %0d plen %0d",
                             o.zone, o.open_c, o.vlen, o.pstart, o.plen, e.zone, e.open_c, e.vlen, e.pstart, e.plen);
                end
            end
        end
        n_checks++; if (inv_viol != 0) begin n_fail++; $display("FAIL abort_invariant got %0d exp 0", inv_viol); end
`ifdef RIEGO_RUN_COUNT_EN
        n_checks++; if (rc_a !== 32'h0001_0000) begin n_fail++; $display("FAIL abort_run_count got %h exp 00010000", rc_a); end
`endif
    endtask

    task automatic test_async_reset;
        do_reset(4'b0001, 4'b0000);
        wait_cyc(215);
        n_checks++; if (pump_n_a !== 1'b0) begin n_fail++; $display("FAIL areset_pre got pump_n %b exp 0", pump_n_a); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (valve_a !== 4'd0 || pump_n_a !== 1'b1 || busy_a !== 1'b0 || cur_a !== 3'd0) begin
            n_fail++; $display("FAIL areset_outputs got valve %b pump_n %b busy %b cur %0d exp 0000 1 0 0", valve_a, pump_n_a, busy_a, cur_a); end
        @(negedge clk);
    endtask

    task automatic test_missed_checks;
        int exp_scan[4] = '{20, 92, 100, 120};
        do_reset(4'b0000, 4'b0001);
        wait_cyc(25);
        req_b = 4'b0000;
        wait_cyc(125);
        n_checks++; if (scan_b_q.size() != 4) begin n_fail++; $display("FAIL missed_scan_count got %0d exp 4", scan_b_q.size()); end
        for (int i = 0; i < 4 && i < scan_b_q.size(); i++) begin
            n_checks++; if (scan_b_q[i] != exp_scan[i]) begin n_fail++; $display("FAIL missed_scan[%0d] got %0d exp %0d", i, scan_b_q[i], exp_scan[i]); end
        end
        n_checks++; if (done_b_q.size() != 1 || done_b_q[0] != 91) begin
            n_fail++; $display("FAIL missed_done got count %0d first %0d exp 1 at 91", done_b_q.size(), (done_b_q.size() > 0) ? done_b_q[0] : -1); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        inv_viol = 0;
        rst_n    = 1'b0;
        en_a = 1'b0; en_b = 1'b0; req_a = 4'd0; req_b = 4'd0;
        test_reset;
        test_single_zone;
        test_round_robin;
        test_snapshot;
        test_abort;
        test_async_reset;
        test_missed_checks;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
